mem_responder: RTL and testbench

//  Target-side endpoint of the LSU io_* bus. Accepts one request at a time,

---
 rtl/mem_responder.sv | 125 ++++++++++++
 tb/tb_mem_responder.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Target-side endpoint of the LSU io_* bus: one request at a time, served from an
// internal word-addressed SRAM after LATENCY cycles plus optional LFSR wait states.
//
// state | meaning
// IDLE  | ready; io_reqValid accepts a request, write lanes commit at this edge
// WAIT  | counting down latency plus any random stall
// RESP  | io_respValid high for exactly this cycle, then back to IDLE
module mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1,
  parameter int          RAND_STALL  = 0,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_reqValid,
  output logic        io_respValid,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  input  logic [31:0] io_addr,
  input  logic [1:0]  io_size,
  input  logic        io_wen,
  input  logic [3:0]  io_wmask,
  output logic        io_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 3) + 1;
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_init_d;
  logic [7:0]        lfsr_q;
  logic [7:0]        lfsr_d;
  logic [1:0]        stall_d;
  logic              resp_valid_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              wen_q;
  logic              range_q;
  logic [31:0]       rd_word_q;
  logic [31:0]       mem_q [DEPTH_WORDS];

  logic [31:0]       offset;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              accept;
  logic              mem_we;
  logic              unused_bits;

  // Range is checked on the full address so nothing aliases back into the array.
  assign offset   = io_addr - BASE_ADDR;
  assign idx      = offset[IDX_W+1:2];
  assign in_range = (io_addr >= BASE_ADDR) && ({1'b0, io_addr} < END_ADDR);
  assign accept   = (state_q == IDLE) && io_reqValid;
  assign mem_we   = accept && io_wen && in_range;

  // Returned word is always the full aligned word, so size and low bits are ignored.
  assign unused_bits = ^{io_size, offset[1:0], offset[31:IDX_W+2]};

  assign lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign stall_d    = (RAND_STALL != 0) ? lfsr_q[1:0] : 2'b00;
  assign cnt_init_d = CNT_W'(LATENCY - 1) + CNT_W'(stall_d);

  assign io_respValid = resp_valid_q;
  assign io_rdata     = rdata_q;
  assign io_err       = err_q;

  // SRAM has no reset; writes and the read sample both happen at the accept edge.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (io_wmask[i]) mem_q[idx][8*i +: 8] <= io_wdata[8*i +: 8];
      end
    end
    if (accept) rd_word_q <= mem_q[idx];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lfsr_q       <= LFSR_SEED;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      wen_q        <= 1'b0;
      range_q      <= 1'b0;
    end else begin
      lfsr_q       <= lfsr_d;
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (io_reqValid) begin
            state_q <= WAIT;
            cnt_q   <= cnt_init_d;
            wen_q   <= io_wen;
            range_q <= in_range;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            rdata_q      <= (range_q && !wen_q) ? rd_word_q : 32'h0;
            err_q        <= !range_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a LATENCY=1 instance for data/range tests
// and a LATENCY=4 random-stall instance for timing and mid-request reset.
module tb_mem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT_B = 4;
  localparam logic [7:0]  SEED  = 8'hA5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        a_req = 0, a_wen = 0, a_resp, a_err;
  logic [3:0]  a_mask = 0;
  logic [1:0]  a_size = 0;
  logic [31:0] a_addr = 0, a_wdata = 0, a_rdata;
  logic        b_req = 0, b_wen = 0, b_resp, b_err;
  logic [3:0]  b_mask = 0;
  logic [1:0]  b_size = 0;
  logic [31:0] b_addr = 0, b_wdata = 0, b_rdata;

  mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1), .RAND_STALL(0),
                  .LFSR_SEED(SEED)) dut_a (
    .clock(clock), .reset(reset), .io_reqValid(a_req), .io_respValid(a_resp),
    .io_wdata(a_wdata), .io_rdata(a_rdata), .io_addr(a_addr), .io_size(a_size),
    .io_wen(a_wen), .io_wmask(a_mask), .io_err(a_err));

  mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT_B), .RAND_STALL(1),
                  .LFSR_SEED(SEED)) dut_b (
    .clock(clock), .reset(reset), .io_reqValid(b_req), .io_respValid(b_resp),
    .io_wdata(b_wdata), .io_rdata(b_rdata), .io_addr(b_addr), .io_size(b_size),
    .io_wen(b_wen), .io_wmask(b_mask), .io_err(b_err));

  int errors = 0;
  int checks = 0;

  logic [31:0] model_a [int];
  logic [31:0] model_b [int];

  // Reference LFSR sequence: 8-bit Fibonacci, taps 8,6,5,4, one step per clock out of reset.
  logic [7:0] m_lfsr;
  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction
  always @(posedge clock) begin
    if (!reset) m_lfsr = SEED;
    else        m_lfsr = lfsr_next(m_lfsr);
  end

  function automatic logic resp_of(input bit sel);
    return sel ? b_resp : a_resp;
  endfunction
  function automatic logic [31:0] rdata_of(input bit sel);
    return sel ? b_rdata : a_rdata;
  endfunction
  function automatic logic err_of(input bit sel);
    return sel ? b_err : a_err;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] lanes;
    lanes = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (old & ~lanes) | (wd & lanes);
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [31:0] addr, input logic wen,
                       input logic [3:0] mask, input logic [31:0] wdata);
    if (sel) begin
      b_req = v; b_addr = addr; b_wen = wen; b_mask = mask; b_wdata = wdata;
      b_size = 2'($urandom_range(0, 3));
    end else begin
      a_req = v; a_addr = addr; a_wen = wen; a_mask = mask; a_wdata = wdata;
      a_size = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic set_valid(input bit sel, input logic v);
    if (sel) b_req = v; else a_req = v;
  endtask

  // Starts and ends just after a falling edge. from_resp: called in the RESP cycle of the
  // previous request with valid still high, so acceptance is one cycle later.
  task automatic do_req(input bit sel, input logic [31:0] addr, input logic wen,
                        input logic [3:0] mask, input logic [31:0] wdata,
                        input bit from_resp, input bit keep,
                        output logic [31:0] rd, output logic er);
    int exp_k;
    int k;
    bit seen;
    drive(sel, 1'b1, addr, wen, mask, wdata);
    if (from_resp) begin
      @(negedge clock);
      checks++;
      if (resp_of(sel) !== 1'b0) begin
        errors++;
        $display("FAIL pulse_width: respValid=%b in cycle after RESP, required 0", resp_of(sel));
      end
    end
    exp_k = (sel ? LAT_B + int'(m_lfsr[1:0]) : 1) + 1;
    seen = 0;
    k = 0;
    while (!seen && k < 20) begin
      @(negedge clock);
      k++;
      if (resp_of(sel) === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || k != exp_k) begin
      errors++;
      $display("FAIL latency: addr=%h pulse after %0d cycles (seen=%0d), required %0d",
               addr, k, seen, exp_k);
    end
    rd = rdata_of(sel);
    er = err_of(sel);
    if (!keep) begin
      set_valid(sel, 1'b0);
      @(negedge clock);
      checks++;
      if (resp_of(sel) !== 1'b0) begin
        errors++;
        $display("FAIL pulse_width: respValid=%b after RESP, required 0", resp_of(sel));
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++;
    if ({a_resp, a_rdata, a_err} !== 34'h0) begin
      errors++;
      $display("FAIL reset_a: resp=%b rdata=%h err=%b, required 0/0/0", a_resp, a_rdata, a_err);
    end
    checks++;
    if ({b_resp, b_rdata, b_err} !== 34'h0) begin
      errors++;
      $display("FAIL reset_b: resp=%b rdata=%h err=%b, required 0/0/0", b_resp, b_rdata, b_err);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    logic er;
    do_req(0, 32'h8000_0010, 1'b1, 4'hF, 32'h1122_3344, 0, 0, rd, er);
    model_a[4] = 32'h1122_3344;
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++;
      $display("FAIL write_resp: rdata=%h err=%b, required 0/0", rd, er);
    end
    do_req(0, 32'h8000_0010, 1'b0, 4'h0, 32'h0, 0, 0, rd, er);
    checks++;
    if (rd !== 32'h1122_3344 || er !== 1'b0) begin
      errors++;
      $display("FAIL read_back: rdata=%h err=%b, required 11223344/0", rd, er);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd, wd;
    logic [3:0] m;
    logic er;
    int w;
    do_req(0, BASE, 1'b1, 4'hF, 32'hFFFF_FFFF, 0, 0, rd, er);
    do_req(0, BASE, 1'b1, 4'b0100, 32'h00AB_0000, 0, 0, rd, er);
    model_a[0] = 32'hFFAB_FFFF;
    do_req(0, BASE, 1'b0, 4'h0, 32'h0, 0, 0, rd, er);
    checks++;
    if (rd !== 32'hFFAB_FFFF || er !== 1'b0) begin
      errors++;
      $display("FAIL lane_write: rdata=%h err=%b, required ffabffff/0", rd, er);
    end
    for (int i = 0; i < 8; i++) begin
      wd = $urandom;
      do_req(0, BASE + 32'(4 * (64 + i)), 1'b1, 4'hF, wd, 0, 0, rd, er);
      model_a[64 + i] = wd;
    end
    for (int i = 0; i < 16; i++) begin
      w  = 64 + int'($urandom_range(0, 7));
      wd = $urandom;
      m  = 4'($urandom_range(0, 15));
      do_req(0, BASE + 32'(4 * w) + 32'($urandom_range(0, 3)), 1'b1, m, wd, 0, 0, rd, er);
      model_a[w] = merge(model_a[w], wd, m);
    end
    for (int i = 0; i < 8; i++) begin
      do_req(0, BASE + 32'(4 * (64 + i)), 1'b0, 4'h0, 32'h0, 0, 0, rd, er);
      checks++;
      if (rd !== model_a[64 + i] || er !== 1'b0) begin
        errors++;
        $display("FAIL lane_random: word %0d rdata=%h err=%b, required %h/0",
                 64 + i, rd, er, model_a[64 + i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic er;
    do_req(0, 32'h8000_0004, 1'b1, 4'hF, 32'hCAFE_BABE, 0, 0, rd, er);
    model_a[1] = 32'hCAFE_BABE;
    do_req(0, 32'h8000_0001, 1'b0, 4'h0, 32'h0, 0, 1, rd, er);
    checks++;
    if (rd !== model_a[0] || er !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: rdata=%h err=%b, required %h/0", rd, er, model_a[0]);
    end
    do_req(0, 32'h8000_0004, 1'b0, 4'h0, 32'h0, 1, 0, rd, er);
    checks++;
    if (rd !== 32'hCAFE_BABE || er !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: rdata=%h err=%b, required cafebabe/0", rd, er);
    end
  endtask

  task automatic test_range();
    logic [31:0] rd;
    logic er;
    logic [31:0] bad [3];
    int keys [4];
    bad[0] = 32'h7FFF_FFFC;
    bad[1] = BASE + 32'(4 * DEPTH);
    bad[2] = 32'hFFFF_FFFC;
    keys[0] = 0; keys[1] = 1; keys[2] = 4; keys[3] = DEPTH - 1;
    do_req(0, BASE + 32'(4 * (DEPTH - 1)), 1'b1, 4'hF, 32'h0BAD_F00D, 0, 0, rd, er);
    model_a[DEPTH - 1] = 32'h0BAD_F00D;
    checks++;
    if (er !== 1'b0) begin
      errors++;
      $display("FAIL range_last_word: err=%b, required 0", er);
    end
    for (int i = 0; i < 3; i++) begin
      do_req(0, 32'h8000_0004, 1'b0, 4'h0, 32'h0, 0, 0, rd, er);
      do_req(0, bad[i], 1'b0, 4'h0, 32'h0, 0, 0, rd, er);
      checks++;
      if (rd !== 32'h0 || er !== 1'b1) begin
        errors++;
        $display("FAIL range_read: addr=%h rdata=%h err=%b, required 0/1", bad[i], rd, er);
      end
      do_req(0, bad[i], 1'b1, 4'hF, 32'hDEAD_DEAD, 0, 0, rd, er);
      checks++;
      if (er !== 1'b1) begin
        errors++;
        $display("FAIL range_write_err: addr=%h err=%b, required 1", bad[i], er);
      end
    end
    for (int i = 0; i < 4; i++) begin
      do_req(0, BASE + 32'(4 * keys[i]), 1'b0, 4'h0, 32'h0, 0, 0, rd, er);
      checks++;
      if (rd !== model_a[keys[i]] || er !== 1'b0) begin
        errors++;
        $display("FAIL range_no_write: word %0d rdata=%h, required %h", keys[i], rd,
                 model_a[keys[i]]);
      end
    end
  endtask

  task automatic test_random_stall();
    logic [31:0] rd, wd, addr;
    logic er;
    int w;
    for (int n = 0; n < 72; n++) begin
      if (n < 8) begin
        w  = n;
        wd = $urandom;
        addr = BASE + 32'(4 * w) + 32'($urandom_range(0, 3));
        do_req(1, addr, 1'b1, 4'hF, wd, n != 0, n != 71, rd, er);
        model_b[w] = wd;
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
          errors++;
          $display("FAIL stall_write: n=%0d rdata=%h err=%b, required 0/0", n, rd, er);
        end
      end else begin
        w = int'($urandom_range(0, 7));
        addr = BASE + 32'(4 * w) + 32'($urandom_range(0, 3));
        do_req(1, addr, 1'b0, 4'h0, 32'h0, 1, n != 71, rd, er);
        checks++;
        if (rd !== model_b[w] || er !== 1'b0) begin
          errors++;
          $display("FAIL stall_read: n=%0d word %0d rdata=%h err=%b, required %h/0",
                   n, w, rd, er, model_b[w]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic er;
    int pulses;
    drive(1, 1'b1, BASE + 32'd8, 1'b0, 4'h0, 32'h0);
    @(negedge clock);
    set_valid(1, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if ({b_resp, b_rdata, b_err} !== 34'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: resp=%b rdata=%h err=%b, required 0/0/0",
               b_resp, b_rdata, b_err);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (b_resp !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_mid_dropped: %0d pulses after reset, required 0", pulses);
    end
    do_req(1, BASE + 32'd8, 1'b0, 4'h0, 32'h0, 0, 0, rd, er);
    checks++;
    if (rd !== model_b[2] || er !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_next: rdata=%h err=%b, required %h/0", rd, er, model_b[2]);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_back_to_back();
    test_range();
    test_random_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
